// File: rtl/vector_store_pkg.sv
// vector_store_pkg: shared state type and sizing helpers for the multi-port vector store.
package vector_store_pkg;
    typedef enum logic {ST_INIT, ST_READY} state_e;
    localparam int MAX_READ_PORTS = 8;
    function automatic int depth_of(input int address_width);
        return 1 << address_width;
    endfunction
endpackage

// File: rtl/vector_store_init_fsm.sv
// vector_store_init_fsm: owns INIT/READY state and the zero-initialisation sweep counter.
module vector_store_init_fsm
    import vector_store_pkg::*;
#(
    parameter int address_width = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    output logic                     ready,
    output logic                     sweep_en,
    output logic [address_width-1:0] sweep_addr
);
    state_e                 state_q, state_d;
    logic [address_width:0] sweep_cnt_q, sweep_cnt_d, sweep_next;

    // The extra MSB of the counter marks the end of the sweep.
    assign sweep_next = sweep_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        if (state_q == ST_INIT) begin
            state_d     = sweep_next[address_width] ? ST_READY : ST_INIT;
            sweep_cnt_d = sweep_next[address_width] ? '0 : sweep_next;
        end else if (clear) begin
            state_d     = ST_INIT;
            sweep_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign ready      = state_q == ST_READY;
    assign sweep_en   = state_q == ST_INIT;
    assign sweep_addr = sweep_cnt_q[address_width-1:0];
endmodule

// File: rtl/multi_port_vector_store.sv
// multi_port_vector_store: 1W/NR synchronous vector store with zeroing sweep.
// Define VECTOR_STORE_WR_BYPASS_EN for write-first forwarding; default is read-first.
module multi_port_vector_store
    import vector_store_pkg::*;
#(
    parameter int value_width    = 16,
    parameter int address_width  = 10,
    parameter int num_read_ports = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   clear,
    output logic                                   ready,
    input  logic                                   wr_en,
    input  logic [address_width-1:0]               wr_addr,
    input  logic [value_width-1:0]                 wr_data,
    input  logic [num_read_ports-1:0]              rd_en,
    input  logic [num_read_ports*address_width-1:0] rd_addr,
    output logic [num_read_ports*value_width-1:0]   rd_data,
    output logic [num_read_ports-1:0]              rd_valid
);
    localparam int DEPTH = depth_of(address_width);

    logic                     sweep_en, usr_wr, mem_we;
    logic [address_width-1:0] sweep_addr, mem_wa;
    logic [value_width-1:0]   mem_wd;
    logic [value_width-1:0]   mem_q [DEPTH];
    logic [value_width-1:0]   rd_data_q [num_read_ports];
    logic                     rd_valid_q [num_read_ports];

    vector_store_init_fsm #(.address_width(address_width)) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .ready     (ready),
        .sweep_en  (sweep_en),
        .sweep_addr(sweep_addr)
    );

    // A write coinciding with clear is dropped; the sweep owns the port in INIT.
    assign usr_wr = ready & wr_en & ~clear & ~reset;
    assign mem_we = sweep_en | usr_wr;
    assign mem_wa = sweep_en ? sweep_addr : wr_addr;
    assign mem_wd = sweep_en ? '0 : wr_data;

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    for (genvar g = 0; g < num_read_ports; g++) begin : g_rd
        logic [address_width-1:0] ra;
        logic [value_width-1:0]   rd_word;
        logic                     fire;
        assign ra   = rd_addr[g*address_width +: address_width];
        assign fire = ready & rd_en[g];
`ifdef VECTOR_STORE_WR_BYPASS_EN
        assign rd_word = (usr_wr && wr_addr == ra) ? wr_data : mem_q[ra];
`else
        assign rd_word = mem_q[ra];
`endif
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q[g]  <= '0;
                rd_valid_q[g] <= 1'b0;
            end else begin
                rd_valid_q[g] <= fire;
                if (fire) rd_data_q[g] <= rd_word;
            end
        end
        assign rd_data[g*value_width +: value_width] = rd_data_q[g];
        assign rd_valid[g]                          = rd_valid_q[g];
    end
endmodule

// File: tb/tb_multi_port_vector_store.sv
// tb_multi_port_vector_store: directed and randomized checks against a behavioural store model.
module tb_multi_port_vector_store;
    localparam int AW = 4;
    localparam int VW = 16;
    localparam int NP = 2;
    localparam int DEPTH = 1 << AW;
`ifdef VECTOR_STORE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 0, reset, clear, ready, wr_en;
    logic [AW-1:0] wr_addr;
    logic [VW-1:0] wr_data;
    logic [NP-1:0] rd_en, rd_valid;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*VW-1:0] rd_data;

    int checks = 0, errors = 0;

    logic [VW-1:0] model [DEPTH];
    bit            mready;
    int            left;
    logic [NP-1:0] exp_valid;
    logic [VW-1:0] exp_data [NP];

    always #5 clk = ~clk;

    multi_port_vector_store #(.value_width(VW), .address_width(AW), .num_read_ports(NP)) dut (
        .clk(clk), .reset(reset), .clear(clear), .ready(ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    function automatic logic [AW-1:0] ra(input int i);
        return rd_addr[i*AW +: AW];
    endfunction

    function automatic logic [VW-1:0] rdd(input int i);
        return rd_data[i*VW +: VW];
    endfunction

    task automatic idle();
        clear = 0; wr_en = 0; rd_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    endtask

    // Advance the model by one clock using the current inputs, then step the DUT.
    task automatic tick();
        if (reset) begin
            mready = 0; left = DEPTH; exp_valid = '0;
            for (int i = 0; i < NP; i++) exp_data[i] = '0;
        end else if (!mready) begin
            exp_valid = '0;
            left--;
            if (left == 0) begin
                mready = 1;
                for (int a = 0; a < DEPTH; a++) model[a] = '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                exp_valid[i] = rd_en[i];
                if (rd_en[i])
                    exp_data[i] = (BYP && wr_en && !clear && wr_addr == ra(i)) ? wr_data : model[ra(i)];
            end
            if (wr_en && !clear) model[wr_addr] = wr_data;
            if (clear) begin mready = 0; left = DEPTH; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int n;
        idle(); reset = 1;
        tick(); tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", rd_valid); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", rd_data); end
        reset = 0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL init_len got %0d ticks want %0d", n, DEPTH); end
    endtask

    task automatic test_init_read();
        idle(); rd_en = 2'b01; rd_addr[3:0] = 4'd5;
        tick();
        checks++; if (rd_valid !== 2'b01 || rdd(0) !== 16'h0000) begin
            errors++; $display("FAIL init_read got v=%b d=%h want v=01 d=0000", rd_valid, rdd(0)); end
        idle();
        tick();
        checks++; if (rd_valid !== 2'b00 || rdd(0) !== 16'h0000) begin
            errors++; $display("FAIL read_hold got v=%b d=%h want v=00 d=0000", rd_valid, rdd(0)); end
    endtask

    task automatic test_basic();
        idle(); wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF;
        tick();
        idle(); rd_en = 2'b11; rd_addr = {4'd3, 4'd3};
        tick();
        checks++; if (rd_valid !== 2'b11 || rd_data !== {16'hBEEF, 16'hBEEF}) begin
            errors++; $display("FAIL basic_rw got v=%b d=%h want v=11 d=beefbeef", rd_valid, rd_data); end
        idle();
    endtask

    task automatic test_rdw();
        logic [VW-1:0] want;
        idle(); wr_en = 1; wr_addr = 7; wr_data = 16'h1111;
        tick();
        wr_data = 16'h2222; rd_en = 2'b10; rd_addr = {4'd7, 4'd0};
        tick();
        want = BYP ? 16'h2222 : 16'h1111;
        checks++; if (rdd(1) !== want || rd_valid !== 2'b10) begin
            errors++; $display("FAIL rdw_same got v=%b d=%h want v=10 d=%h", rd_valid, rdd(1), want); end
        idle(); rd_en = 2'b10; rd_addr = {4'd7, 4'd0};
        tick();
        checks++; if (rdd(1) !== 16'h2222) begin
            errors++; $display("FAIL rdw_after got %h want 2222", rdd(1)); end
        idle();
    endtask

    task automatic test_clear();
        int n;
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1; wr_addr = AW'(a); wr_data = 16'hA5A5;
            tick();
        end
        idle(); clear = 1; wr_en = 1; wr_addr = 2; wr_data = 16'h1234; rd_en = 2'b01; rd_addr[3:0] = 4'd9;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clear_ready got %b want 0", ready); end
        checks++; if (rd_valid !== 2'b01 || rdd(0) !== 16'hA5A5) begin
            errors++; $display("FAIL clear_read got v=%b d=%h want v=01 d=a5a5", rd_valid, rdd(0)); end
        idle();
        n = 0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL clear_len got %0d want %0d", n, DEPTH); end
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 2'b11; rd_addr = {AW'(DEPTH - 1 - a), AW'(a)};
            tick();
            checks++; if (rd_valid !== 2'b11 || rd_data !== 32'h0) begin
                errors++; $display("FAIL clear_zero a=%0d got v=%b d=%h want v=11 d=0", a, rd_valid, rd_data); end
        end
        idle();
    endtask

    task automatic test_ignored();
        int n;
        logic [NP*VW-1:0] held;
        idle(); wr_en = 1; wr_addr = 6; wr_data = 16'h7777;
        tick();
        idle(); reset = 1; tick(); reset = 0;
        held = rd_data;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            rd_en = 2'b11; rd_addr = {4'd6, 4'd6}; wr_en = 1; wr_addr = 6; wr_data = 16'hCAFE;
            tick(); n++;
            if (ready !== 1'b1) begin
                checks++; if (rd_valid !== 2'b00 || rd_data !== held) begin
                    errors++; $display("FAIL init_ignore got v=%b d=%h want v=00 d=%h", rd_valid, rd_data, held); end
            end
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL ignore_len got %0d want %0d", n, DEPTH); end
        idle(); rd_en = 2'b01; rd_addr[3:0] = 4'd6;
        tick();
        checks++; if (rd_valid !== 2'b01 || rdd(0) !== 16'h0000) begin
            errors++; $display("FAIL ignore_mem got v=%b d=%h want v=01 d=0000", rd_valid, rdd(0)); end
        idle();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        idle(); reset = 1; tick(); reset = 0;
        for (int k = 0; k < 9; k++) tick();
        reset = 1; tick();
        checks++; if (ready !== 1'b0 || rd_valid !== 2'b00 || rd_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset got r=%b v=%b d=%h want r=0 v=00 d=0", ready, rd_valid, rd_data); end
        reset = 0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL mid_len got %0d want %0d", n, DEPTH); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            clear   = ($urandom_range(0, 39) == 0);
            wr_en   = $urandom_range(0, 1);
            wr_addr = AW'($urandom_range(0, 3));
            wr_data = VW'($urandom);
            rd_en   = NP'($urandom);
            for (int i = 0; i < NP; i++)
                rd_addr[i*AW +: AW] = $urandom_range(0, 1) ? wr_addr : AW'($urandom_range(0, 3));
            tick();
            checks++; if (ready !== mready) begin errors++; $display("FAIL rnd_ready k=%0d got %b want %b", k, ready, mready); end
            checks++; if (rd_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid k=%0d got %b want %b", k, rd_valid, exp_valid); end
            for (int i = 0; i < NP; i++) begin
                checks++; if (rdd(i) !== exp_data[i]) begin
                    errors++; $display("FAIL rnd_data k=%0d p=%0d got %h want %h", k, i, rdd(i), exp_data[i]); end
            end
        end
        idle();
    endtask

    initial begin
        idle(); reset = 1;
        mready = 0; left = DEPTH; exp_valid = '0;
        for (int i = 0; i < NP; i++) exp_data[i] = '0;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        test_reset();
        test_init_read();
        test_basic();
        test_rdw();
        test_clear();
        test_ignored();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_port_vector_store.md
Name: multi_port_vector_store

Overview:
Parametrised successor to the single-vector store: one write port plus num_read_ports independent synchronous read ports over a 2**address_width-deep memory. The block adds a hardware zero-initialisation sweep after reset or on request, a ready flag, per-port read valids and defined read-during-write behaviour. It sits beside the datapath as the vector operand store. Reads and writes are no longer mutually exclusive on any port.

Parameters:
value_width, 16, bits per stored word
address_width, 10, address bits; depth = 2**address_width
num_read_ports, 2, number of read ports, 1..8

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
clear  in  1  pulse; zero the whole memory
ready  out  1  high when the store accepts reads and writes
wr_en  in  1  write strobe
wr_addr  in  address_width  write address
wr_data  in  value_width  write data
rd_en  in  num_read_ports  per-port read strobe
rd_addr  in  num_read_ports*address_width  packed read addresses; port i at [i*address_width +: address_width]
rd_data  out  num_read_ports*value_width  packed read data, same packing
rd_valid  out  num_read_ports  per-port data-valid

Behaviour:
- Reset values: ready=0, rd_valid=0, rd_data=0, sweep counter=0, state=INIT. Memory contents are not reset directly; the INIT sweep clears them.
- States: INIT, READY.
- INIT:
  - Each cycle, write 0 to mem[sweep_cnt] and increment sweep_cnt.
  - On the cycle that writes address 2**address_width-1, go to READY the next cycle.
  - Sweep takes exactly 2**address_width cycles; ready rises in the following cycle.
  - While in INIT: wr_en and rd_en are ignored, rd_valid stays 0, rd_data holds its last value, and clear is ignored.
- READY:
  - ready=1.
  - wr_en=1 writes wr_data to mem[wr_addr] at the clock edge.
  - Read: rd_en[i]=1 at edge N gives rd_data[i]=mem[rd_addr[i]] and rd_valid[i]=1 after edge N+1, a latency of 1 cycle.
  - rd_en[i]=0 gives rd_valid[i]=0 the next cycle, and rd_data[i] holds.
  - Several ports may read the same address in the same cycle; all of them return the same word.
- clear in READY:
  - The next state is INIT with sweep_cnt=0, and ready drops the next cycle.
  - A write in the same cycle as clear is discarded. Reads issued in that cycle complete normally.
- Read-during-write, same address, same cycle: read-first. The read returns the old contents, and the new value is visible from the following cycle (see Optional Feature).
- Reset asserted mid-sweep or mid-operation: return to INIT, sweep_cnt=0, outputs at reset values. The sweep always restarts from address 0.
- Addresses are always in range (full power-of-two depth), so there is no bounds check.
- sweep_cnt is address_width+1 bits wide; its MSB terminates the sweep, so the count never wraps silently.

Optional Feature:
Macro: VECTOR_STORE_WR_BYPASS_EN.
- Defined: a same-cycle write and read to the same address forwards wr_data to that port's rd_data (write-first). This is per port, and any number of ports may hit at once.
- Undefined: read-first as described above.
- Sweep behaviour is identical in both builds. In INIT, reads are ignored, so there is no forwarding.

Decomposition:
- Package vector_store_pkg:
  - state enum {ST_INIT, ST_READY}
  - localparam function/constant for depth = 2**address_width
  - max port count constant (8)
- Sub-module vector_store_init_fsm: owns state, sweep_cnt, ready, and the sweep write address/enable.
- The top level muxes the sweep write against the user write port and instantiates the memory plus num_read_ports read registers in a generate loop.

Test Plan:
Bench parameters: address_width=4, value_width=16, num_read_ports=2.
- Init: release reset -> ready=0 for exactly 16 cycles, ready=1 on cycle 17; port 0 reading addr 5 then returns 0x0000 with rd_valid=1 one cycle after rd_en.
- Basic write/read: write 0xBEEF @3, next cycle port0 reads 3 and port1 reads 3 -> both rd_data=0xBEEF, rd_valid=2'b11 one cycle later.
- Read-during-write: mem[7]=0x1111, then same cycle write 0x2222 @7 with port1 reading 7:
  - without macro: rd_data1=0x1111, and the next read returns 0x2222;
  - with VECTOR_STORE_WR_BYPASS_EN: rd_data1=0x2222.
- Clear: fill addrs 0..15 with 0xA5A5, pulse clear together with a write of 0x1234 @2 -> ready=0 for 16 cycles; afterwards all addresses read 0x0000, and addr 2 is not 0x1234.
- Ignored access: rd_en=2'b11 and wr_en during INIT -> rd_valid stays 0, and after ready the written address reads 0x0000.
- Reset mid-sweep: assert reset at sweep address 9 -> sweep restarts at 0, and ready rises 16 cycles after reset deasserts.
